conv3x3_stream: RTL and testbench

CONV3X3_STREAM -- requirements
Module: conv3x3_stream

---
 rtl/conv3x3_pkg.sv | 19 +
 rtl/conv3x3_mac.sv | 53 +++++
 rtl/conv3x3_stream.sv | 140 ++++++++++++++
 tb/tb_conv3x3_stream.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/conv3x3_pkg.sv
// conv3x3_pkg: shared FSM encoding, frame count rules and MAC width rules for the 3x3 stream convolver
package conv3x3_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_PRIME, ST_FETCH, ST_DRAIN, ST_DONE} state_e;
  localparam int KTAPS = 9;
  localparam int GUARD_BITS = 4;
  function automatic int reads_per_frame(int w, int h);
    return 3 * w * (h - 2);
  endfunction
  function automatic int results_per_frame(int w, int h);
    return (w - 2) * (h - 2);
  endfunction
  function automatic int prod_width(int rw, int cw);
    return rw + cw + 1;
  endfunction
  // the 9-term sum needs 4 guard bits above a single product to never overflow
  function automatic int sum_width(int rw, int cw);
    return prod_width(rw, cw) + GUARD_BITS;
  endfunction
endpackage

// File: rtl/conv3x3_mac.sv
// conv3x3_mac: two-stage 3x3 multiply-accumulate with arithmetic shift and unsigned saturation
module conv3x3_mac
  import conv3x3_pkg::*;
#(
  parameter int RAM_WIDTH  = 8,
  parameter int COEF_WIDTH = 8,
  parameter int SHIFT      = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_valid,
  input  logic [KTAPS*RAM_WIDTH-1:0]      i_pix,
  input  logic [KTAPS*COEF_WIDTH-1:0]     i_coef,
  output logic                            o_valid,
  output logic [RAM_WIDTH-1:0]            o_data
);
  localparam int PW = prod_width(RAM_WIDTH, COEF_WIDTH);
  localparam int SW = sum_width(RAM_WIDTH, COEF_WIDTH);
  logic signed [PW-1:0] prod_d [KTAPS];
  logic signed [PW-1:0] prod_q [KTAPS];
  logic                 v1_q;
  logic signed [SW-1:0] sum_d;
  logic signed [SW-1:0] sh_d;
  logic [RAM_WIDTH-1:0] sat_d;
  always_comb begin
    for (int k = 0; k < KTAPS; k++)
      prod_d[k] = PW'($signed({1'b0, i_pix[k*RAM_WIDTH +: RAM_WIDTH]})) * PW'($signed(i_coef[k*COEF_WIDTH +: COEF_WIDTH]));
  end
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < KTAPS; k++)
      sum_d = sum_d + SW'(prod_q[k]);
    sh_d  = sum_d >>> SHIFT;
    sat_d = sh_d[SW-1] ? '0 : (|sh_d[SW-2:RAM_WIDTH]) ? '1 : sh_d[RAM_WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q    <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      for (int k = 0; k < KTAPS; k++)
        prod_q[k] <= '0;
    end else begin
      v1_q    <= i_valid;
      o_valid <= v1_q;
      if (i_valid)
        for (int k = 0; k < KTAPS; k++)
          prod_q[k] <= prod_d[k];
      if (v1_q)
        o_data <= sat_d;
    end
  end
endmodule

// File: rtl/conv3x3_stream.sv
// conv3x3_stream: streams column triplets from an upstream frame buffer and writes 3x3-convolved pixels downstream
module conv3x3_stream
  import conv3x3_pkg::*;
#(
  parameter int RAM_WIDTH    = 8,
  parameter int IMAGE_WIDTH  = 10,
  parameter int IMAGE_HEIGHT = 10,
  parameter int COEF_WIDTH   = 8,
  parameter int SHIFT        = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_start,
  input  logic                         i_coef_valid,
  input  logic [3:0]                   i_coef_idx,
  input  logic signed [COEF_WIDTH-1:0] i_coef,
  output logic                         o_read_valid,
  input  logic [RAM_WIDTH-1:0]         i_data_from_mem,
  output logic                         o_load_valid,
  output logic [RAM_WIDTH-1:0]         o_data_to_mem,
  output logic                         o_busy,
  output logic                         o_done
);
  localparam int READS   = reads_per_frame(IMAGE_WIDTH, IMAGE_HEIGHT);
  localparam int RESULTS = results_per_frame(IMAGE_WIDTH, IMAGE_HEIGHT);
  localparam int RCW = $clog2(READS + 1);
  localparam int QCW = $clog2(RESULTS + 1);
  localparam int CCW = $clog2(IMAGE_WIDTH);
  localparam int SCW = $clog2(IMAGE_HEIGHT);
  state_e                       state_q, state_d;
  logic [RCW-1:0]               rd_cnt_q;
  logic [QCW-1:0]               res_cnt_q;
  logic [1:0]                   k_q;
  logic [CCW-1:0]               col_q;
  logic [SCW-1:0]               strip_q;
  logic                         samp_q, wv_q, samp, bottom, last_col;
  logic [RAM_WIDTH-1:0]         top_q, mid_q;
  logic [RAM_WIDTH-1:0]         win_q [3][3];
  logic signed [COEF_WIDTH-1:0] coef_q [KTAPS];
  logic [KTAPS*RAM_WIDTH-1:0]   pix_flat;
  logic [KTAPS*COEF_WIDTH-1:0]  coef_flat;
  always_comb begin
    state_d      = state_q;
    o_read_valid = 1'b0;
    case (state_q)
      ST_IDLE:  state_d = i_start ? ST_PRIME : ST_IDLE;
      ST_PRIME: begin
        o_read_valid = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_FETCH: begin
        o_read_valid = 1'b1;
        state_d      = (rd_cnt_q == RCW'(READS - 1)) ? ST_DRAIN : ST_FETCH;
      end
      ST_DRAIN: state_d = (o_load_valid && res_cnt_q == QCW'(RESULTS - 1)) ? ST_DONE : ST_DRAIN;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end
  assign o_busy   = state_q != ST_IDLE;
  assign o_done   = state_q == ST_DONE;
  // samp_q marks the cycle a FETCH read's data is on the bus; the PRIME word never sets it
  assign samp     = samp_q && strip_q != SCW'(IMAGE_HEIGHT - 2);
  assign bottom   = samp && k_q == 2'd2;
  assign last_col = col_q == CCW'(IMAGE_WIDTH - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rd_cnt_q  <= '0;
      res_cnt_q <= '0;
      samp_q    <= 1'b0;
      wv_q      <= 1'b0;
      k_q       <= '0;
      col_q     <= '0;
      strip_q   <= '0;
      top_q     <= '0;
      mid_q     <= '0;
    end else begin
      state_q   <= state_d;
      samp_q    <= state_q == ST_FETCH;
      rd_cnt_q  <= (state_q == ST_IDLE) ? '0 : rd_cnt_q + RCW'(state_q == ST_FETCH);
      res_cnt_q <= (state_q == ST_IDLE) ? '0 : res_cnt_q + QCW'(o_load_valid);
      wv_q      <= bottom && col_q >= CCW'(2);
      if (state_q == ST_IDLE) begin
        k_q     <= '0;
        col_q   <= '0;
        strip_q <= '0;
      end else if (samp) begin
        k_q <= bottom ? 2'd0 : k_q + 2'd1;
        if (k_q == 2'd0) top_q <= i_data_from_mem;
        if (k_q == 2'd1) mid_q <= i_data_from_mem;
        if (bottom) begin
          col_q   <= last_col ? '0 : col_q + CCW'(1);
          strip_q <= strip_q + SCW'(last_col);
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
    end else if (bottom) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= top_q;
      win_q[1][2] <= mid_q;
      win_q[2][2] <= i_data_from_mem;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < KTAPS; k++)
        coef_q[k] <= (k == 4) ? COEF_WIDTH'(2 ** SHIFT) : '0;
    end else if (state_q == ST_IDLE && i_coef_valid) begin
      for (int k = 0; k < KTAPS; k++)
        if (i_coef_idx == 4'(k)) coef_q[k] <= i_coef;
    end
  end
  for (genvar g = 0; g < KTAPS; g++) begin : g_pack
    assign pix_flat[g*RAM_WIDTH +: RAM_WIDTH]    = win_q[g/3][g%3];
    assign coef_flat[g*COEF_WIDTH +: COEF_WIDTH] = coef_q[g];
  end
  conv3x3_mac #(
    .RAM_WIDTH (RAM_WIDTH),
    .COEF_WIDTH(COEF_WIDTH),
    .SHIFT     (SHIFT)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .i_valid(wv_q),
    .i_pix  (pix_flat),
    .i_coef (coef_flat),
    .o_valid(o_load_valid),
    .o_data (o_data_to_mem)
  );
endmodule

// File: tb/tb_conv3x3_stream.sv
// tb_conv3x3_stream: upstream memory model plus scoreboard of reference 3x3 results and per-frame vector table
module tb_conv3x3_stream;
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              i_start = 1'b0;
  logic              i_coef_valid = 1'b0;
  logic [3:0]        i_coef_idx = '0;
  logic signed [7:0] i_coef = '0;
  logic              o_read_valid;
  logic [7:0]        i_data_from_mem = '0;
  logic              o_load_valid;
  logic [7:0]        o_data_to_mem;
  logic              o_busy, o_done;

  conv3x3_stream dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_coef_valid(i_coef_valid),
    .i_coef_idx(i_coef_idx), .i_coef(i_coef), .o_read_valid(o_read_valid),
    .i_data_from_mem(i_data_from_mem), .o_load_valid(o_load_valid),
    .o_data_to_mem(o_data_to_mem), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  typedef struct {int val; int due;} exp_t;
  typedef struct {bit wr; int ctr; int oth; int pix; int first; int last;} vec_t;

  exp_t sb[$];
  vec_t vt[6];
  int   checks = 0, errors = 0;
  int   cyc = 0, rd_n = 0, wr_n = 0, dn_n = 0, first_v = -1, last_v = -1;
  int   kc[9];
  int   img[10][10];
  int   asym[9];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model(input int s, input int c);
    int sum, sh;
    sum = 0;
    for (int r = 0; r < 3; r++)
      for (int q = 0; q < 3; q++)
        sum += kc[r*3+q] * img[s+r][c-2+q];
    sh = sum >>> 4;
    return sh < 0 ? 0 : (sh > 255 ? 255 : sh);
  endfunction

  function automatic void set_img(input int mode);
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        img[r][c] = (mode == 0) ? 10*r + c : 255;
  endfunction

  // upstream buffer (1-cycle latency, first read returns a stale word) and downstream checker
  initial begin
    bit rv;
    int seq, s, c, k;
    exp_t e;
    forever begin
      @(negedge clk);
      rv = o_read_valid;
      if (o_load_valid) begin
        wr_n++;
        if (wr_n == 1) first_v = o_data_to_mem;
        last_v = o_data_to_mem;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got %0d with no result pending", o_data_to_mem);
        end else begin
          e = sb.pop_front();
          chk("result_value", int'(o_data_to_mem), e.val);
          chk("result_latency_cycle", cyc, e.due);
        end
      end
      if (o_done) dn_n++;
      if (o_busy === 1'b0 && (o_read_valid === 1'b1 || o_load_valid === 1'b1)) begin
        errors++;
        $display("FAIL strobe_in_idle: read=%0b load=%0b required 0", o_read_valid, o_load_valid);
      end
      if (rv) rd_n++;
      @(posedge clk);
      #1;
      if (rv) begin
        if (rd_n == 1) i_data_from_mem = 8'hEE;
        else begin
          seq = rd_n - 2;
          if (seq < 240) begin
            s = seq / 30;
            c = (seq / 3) % 10;
            k = seq % 3;
            i_data_from_mem = 8'(img[s+k][c]);
            if (k == 2 && c >= 2) sb.push_back('{model(s, c), cyc + 3});
          end else i_data_from_mem = 8'h00;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2 reset = 1'b0;
    sb.delete();
    for (int k = 0; k < 9; k++) kc[k] = (k == 4) ? 16 : 0;
    @(negedge clk);
    chk("reset_read_valid", int'(o_read_valid), 0);
    chk("reset_load_valid", int'(o_load_valid), 0);
    chk("reset_busy", int'(o_busy), 0);
    chk("reset_done", int'(o_done), 0);
    chk("reset_data", int'(o_data_to_mem), 0);
  endtask

  task automatic write_coef(input int idx, input int val);
    @(posedge clk); #2;
    i_coef_valid = 1'b1;
    i_coef_idx   = 4'(idx);
    i_coef       = 8'(val);
    @(posedge clk); #2 i_coef_valid = 1'b0;
  endtask

  task automatic start_frame();
    rd_n = 0; wr_n = 0; dn_n = 0; first_v = -1; last_v = -1;
    @(posedge clk); #2 i_start = 1'b1;
    @(posedge clk); #2 i_start = 1'b0;
  endtask

  task automatic run_frame();
    start_frame();
    for (int i = 0; i < 3000 && dn_n == 0; i++) @(posedge clk);
    repeat (6) @(posedge clk);
    #2;
  endtask

  task automatic frame_counts(input string tag);
    chk({tag, "_reads"}, rd_n, 241);
    chk({tag, "_writes"}, wr_n, 64);
    chk({tag, "_done_pulses"}, dn_n, 1);
    chk({tag, "_pending"}, sb.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b0,  16,  0, 0,  11,  88};
    vt[1] = '{1'b1,   1,  1, 0,   6,  49};
    vt[2] = '{1'b1, 127, 127, 1, 255, 255};
    vt[3] = '{1'b1,  -1, -1, 1,   0,   0};
    vt[4] = '{1'b1,  32,  0, 0,  22, 176};
    vt[5] = '{1'b1,   0,  2, 0,  11,  88};
    asym = '{3, -2, 1, 0, 5, 0, -1, 4, 6};
    do_reset();
    for (int v = 0; v < 6; v++) begin
      set_img(vt[v].pix);
      if (vt[v].wr)
        for (int k = 0; k < 9; k++) begin
          kc[k] = (k == 4) ? vt[v].ctr : vt[v].oth;
          write_coef(k, kc[k]);
        end
      run_frame();
      frame_counts($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_first", v), first_v, vt[v].first);
      chk($sformatf("vec%0d_last", v), last_v, vt[v].last);
    end

    // reset mid-frame aborts; the identity kernel comes back
    set_img(0);
    for (int k = 0; k < 9; k++) begin
      kc[k] = 1;
      write_coef(k, 1);
    end
    start_frame();
    for (int i = 0; i < 500 && rd_n < 100; i++) @(posedge clk);
    chk("reads_before_reset", int'(rd_n >= 100), 1);
    do_reset();
    @(negedge clk);
    chk("after_reset_read_valid", int'(o_read_valid), 0);
    chk("after_reset_load_valid", int'(o_load_valid), 0);
    run_frame();
    frame_counts("post_reset");
    chk("post_reset_first", first_v, 11);
    chk("post_reset_last", last_v, 88);

    // out-of-range indices ignored; mid-frame start and coefficient write ignored
    for (int k = 0; k < 9; k++) begin
      kc[k] = asym[k];
      write_coef(k, asym[k]);
    end
    write_coef(9, 77);
    write_coef(15, -5);
    fork
      run_frame();
      begin
        repeat (60) @(posedge clk);
        #3;
        i_start = 1'b1; i_coef_valid = 1'b1; i_coef_idx = 4'd4; i_coef = 8'sd50;
        @(posedge clk); #3;
        i_start = 1'b0; i_coef_valid = 1'b0;
      end
    join
    frame_counts("midframe");
    chk("midframe_first", first_v, model(0, 2));
    chk("midframe_last", last_v, model(7, 9));
    chk("idle_after_frame_busy", int'(o_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
